mandel_iter_core: RTL and testbench
===================================

Name: mandel_iter_core

Overview:
- Parametrised single-multiplier escape-time iterator for the Mandelbrot/Julia renderer.
- Accepts one point (c, optional z0, per-job iteration cap, pixel tag) over a valid/ready handshake.
- Iterates z <= z^2 + c with one time-shared fixed-point multiplier, three cycles per iteration.
- Returns the iteration count, an escaped/bounded flag and the tag. Sits between the pixel scheduler and the colour-map/VGA writer; N instances form the iterator array.

Parameters:
- WIDTH, 27, total signed fixed-point width of all z/c values.
- FRAC, 23, fraction bits (27/23 = 4.23 format); integer range must hold ±4.0.
- ITER_W, 10, width of iteration counter and max-iteration input.
- TAG_W, 19, width of the opaque pixel tag carried from input to output.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_val  in  1  job valid
- in_rdy  out  1  core can accept a job
- in_c_r, in_c_i  in  WIDTH  signed c (real, imaginary)
- in_z0_r, in_z0_i  in  WIDTH  signed starting z; used only when in_julia=1
- in_julia  in  1  1: z0 = in_z0; 0: z0 = 0 (Mandelbrot)
- in_max_iter  in  ITER_W  iteration cap; 0 is treated as 1
- in_tag  in  TAG_W  pixel tag
- out_val  out  1  result valid
- out_rdy  in  1  downstream accepts result
- out_iter  out  ITER_W  completed iterations
- out_escaped  out  1  1: escape detected; 0: cap reached
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; out_val=0; in_rdy=0 while reset is high.
  - out_iter, out_escaped and out_tag clear to 0; z, c and square registers clear to 0.
- States: IDLE, SQ_R, SQ_I, CROSS, DONE.
- IDLE:
  - in_rdy=1.
  - On in_val&&in_rdy, latch c, z (z0 or 0), cap (0→1), tag; n=0; go to SQ_R.
- SQ_R: multiplier gets zr*zr; register zr_sq; go to SQ_I.
- SQ_I: multiplier gets zi*zi; register zi_sq; go to CROSS.
- CROSS: multiplier gets zr*zi.
  - Escape test on z_n: zr_sq+zi_sq >= 4.0 (1<<(FRAC+2)), or either square saturated, or |zr|>2.0, or |zi|>2.0.
  - Escape → DONE, out_iter=n, out_escaped=1; z is not updated.
  - Otherwise:
    - zr <= zr_sq - zi_sq + c_r; zi <= 2*(zr*zi) + c_i; n <= n+1.
    - If n+1 == cap → DONE, out_iter=n+1, out_escaped=0.
    - Else → SQ_R.
- DONE:
  - out_val=1; out_iter, out_escaped and out_tag are registered and stable while out_rdy=0.
  - On out_rdy → IDLE.
  - A new job cannot be accepted in the same cycle as DONE→IDLE; one bubble is allowed.
- Latency: from the handshake cycle, out_val rises 3*k+1 cycles later, where k = number of CROSS visits (escape at n=j gives k=j+1; reaching the cap gives k=cap).
- Arithmetic:
  - Multiplier keeps the full 2*WIDTH product and selects bits [FRAC+WIDTH-1:FRAC].
  - If discarded high bits are not sign copies, it saturates to ±max and flags overflow.
  - Adds and subtracts saturate to WIDTH; the doubling saturates.
  - A saturation flag on zr_sq/zi_sq forces escape.
- Reset mid-iteration aborts the job; no result is emitted.
- in_val while busy is ignored (in_rdy=0); the inputs need not be held.

Decomposition:
- Package mandel_pkg:
  - state enum;
  - localparams ONE=1<<FRAC, TWO, FOUR derived from FRAC;
  - a saturating-add function.
- Sub-module mandel_fx_mult (WIDTH, FRAC): combinational signed multiply with bit select, saturation and overflow output. The single instance is muxed by state.

Test Plan:
- Mandelbrot, c=(0,0), cap=100, out_rdy=1 → out_iter=100, out_escaped=0, out_val exactly 301 cycles after handshake.
- c=(2.0,0)=(0x1000000,0) → z1=2.0, escape at n=1: out_iter=1, out_escaped=1, latency 7.
- c=(-2.0,0) → z1=-2.0, escape at n=1; c=(0.25,0), cap=50 → bounded, out_iter=50, escaped=0.
- Julia, z0=(1.5,0), c=0, cap=20 → n=0 gives 2.25 (no escape), z1=2.25 → out_iter=1, escaped=1, tag 0x5A5A5 returned intact.
- cap=0 with c=0 → out_iter=1, escaped=0. c=(3.9,3.9) → escape at n=1 via saturation, no wrap to a small value.
- Hold out_rdy=0 for 10 cycles in DONE → outputs stable, in_rdy=0. Assert reset mid-iteration → out_val=0 and a new job runs correctly afterwards.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types, fixed-point constants and saturating arithmetic for the escape-time iterator.
// Constants are for the default 4.23 format; the core rederives them when FRAC differs.
package mandel_pkg;

  localparam int WIDTH_DEF  = 27;
  localparam int FRAC_DEF   = 23;
  localparam int ITER_W_DEF = 10;
  localparam int TAG_W_DEF  = 19;

  localparam longint ONE  = 64'sd1 <<< FRAC_DEF;
  localparam longint TWO  = ONE <<< 1;
  localparam longint FOUR = ONE <<< 2;

  typedef enum logic [2:0] {
    IDLE,
    SQ_R,
    SQ_I,
    CROSS,
    DONE
  } state_t;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s  = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (s > mx)      sat_add = mx;
    else if (s < mn) sat_add = mn;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/mandel_fx_mult.sv
// Combinational signed fixed-point multiply: full product, keep [FRAC+WIDTH-1:FRAC],
// saturate to the signed range and flag overflow when the dropped high bits are not sign copies.
module mandel_fx_mult #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 23
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p,
  output logic                    ovf
);

  localparam int HW = 2 * WIDTH - FRAC;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [HW-1:0] prod_hi;

  // Fraction bits are shifted out before narrowing, so every kept bit is either result or range check.
  assign prod_hi = HW'(((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC);

  assign ovf = (prod_hi[HW-1:WIDTH-1] != {(HW-WIDTH+1){prod_hi[HW-1]}});
  assign p   = ovf ? (prod_hi[HW-1] ? MINV : MAXV) : prod_hi[WIDTH-1:0];

endmodule

// File: rtl/mandel_iter_core.sv
// Escape-time iterator z <= z^2 + c on one shared multiplier, 3 cycles per iteration;
// result appears 3*k+1 cycles after accept and is held in DONE until out_rdy.
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ITER_W = ITER_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic signed [WIDTH-1:0] in_c_r,
  input  logic signed [WIDTH-1:0] in_c_i,
  input  logic signed [WIDTH-1:0] in_z0_r,
  input  logic signed [WIDTH-1:0] in_z0_i,
  input  logic                    in_julia,
  input  logic [ITER_W-1:0]       in_max_iter,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [ITER_W-1:0]       out_iter,
  output logic                    out_escaped,
  output logic [TAG_W-1:0]        out_tag
);

  localparam longint ONE_M  = (FRAC == FRAC_DEF) ? ONE  : (64'sd1 <<< FRAC);
  localparam longint TWO_M  = (FRAC == FRAC_DEF) ? TWO  : (ONE_M <<< 1);
  localparam longint FOUR_M = (FRAC == FRAC_DEF) ? FOUR : (ONE_M <<< 2);

  localparam logic signed [WIDTH-1:0] TWO_W     = WIDTH'(TWO_M);
  localparam logic signed [WIDTH-1:0] NEG_TWO_W = WIDTH'(-TWO_M);
  localparam logic signed [WIDTH:0]   FOUR_W    = (WIDTH+1)'(FOUR_M);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] zr, zi, cr, ci;
  logic signed [WIDTH-1:0] zr_sq, zi_sq;
  logic                    sq_r_ovf, sq_i_ovf;
  logic [ITER_W-1:0]       n, cap, n_inc;
  logic [TAG_W-1:0]        tag;

  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic                    mul_ovf;

  logic signed [WIDTH:0]   mag_sum;
  logic                    z_big, escape, cap_hit;
  logic signed [WIDTH-1:0] diff_sq, cross2, zr_nxt, zi_nxt;

  // SQ_R: zr*zr, SQ_I: zi*zi, CROSS: zr*zi.
  assign mul_a = (state == SQ_I) ? zi : zr;
  assign mul_b = (state == SQ_R) ? zr : zi;

  mandel_fx_mult #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_mult (
    .a  (mul_a),
    .b  (mul_b),
    .p  (mul_p),
    .ovf(mul_ovf)
  );

  // Escape is judged on z_n (the squares just registered), before z is advanced.
  assign mag_sum = (WIDTH+1)'(zr_sq) + (WIDTH+1)'(zi_sq);
  assign z_big   = (zr > TWO_W) || (zr < NEG_TWO_W) || (zi > TWO_W) || (zi < NEG_TWO_W);
  assign escape  = (mag_sum >= FOUR_W) || sq_r_ovf || sq_i_ovf || z_big;
  assign n_inc   = n + ITER_W'(1);
  assign cap_hit = (n_inc == cap);

  assign diff_sq = WIDTH'(sat_add(64'(zr_sq), -(64'(zi_sq)), WIDTH));
  assign cross2  = WIDTH'(sat_add(64'(mul_p), 64'(mul_p), WIDTH));
  assign zr_nxt  = WIDTH'(sat_add(64'(diff_sq), 64'(cr), WIDTH));
  assign zi_nxt  = WIDTH'(sat_add(64'(cross2), 64'(ci), WIDTH));

  assign in_rdy  = (state == IDLE) && !reset;
  assign out_val = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_val) state_nxt = SQ_R;
      SQ_R:    state_nxt = SQ_I;
      SQ_I:    state_nxt = CROSS;
      CROSS:   state_nxt = (escape || cap_hit) ? DONE : SQ_R;
      DONE:    if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zr          <= '0;
      zi          <= '0;
      cr          <= '0;
      ci          <= '0;
      zr_sq       <= '0;
      zi_sq       <= '0;
      sq_r_ovf    <= 1'b0;
      sq_i_ovf    <= 1'b0;
      n           <= '0;
      cap         <= '0;
      tag         <= '0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      out_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            cr  <= in_c_r;
            ci  <= in_c_i;
            zr  <= in_julia ? in_z0_r : '0;
            zi  <= in_julia ? in_z0_i : '0;
            cap <= (in_max_iter == '0) ? ITER_W'(1) : in_max_iter;
            tag <= in_tag;
            n   <= '0;
          end
        end
        SQ_R: begin
          zr_sq    <= mul_p;
          sq_r_ovf <= mul_ovf;
        end
        SQ_I: begin
          zi_sq    <= mul_p;
          sq_i_ovf <= mul_ovf;
        end
        CROSS: begin
          if (escape) begin
            out_iter    <= n;
            out_escaped <= 1'b1;
            out_tag     <= tag;
          end else begin
            zr <= zr_nxt;
            zi <= zi_nxt;
            n  <= n_inc;
            if (cap_hit) begin
              out_iter    <= n_inc;
              out_escaped <= 1'b0;
              out_tag     <= tag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Bench for mandel_iter_core: directed spec cases plus random jobs against a plain-arithmetic model.
module tb_mandel_iter_core;

  localparam int WIDTH  = 27;
  localparam int FRAC   = 23;
  localparam int ITER_W = 10;
  localparam int TAG_W  = 19;
  localparam longint ONE  = 64'sd1 <<< FRAC;
  localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

  logic                    clk;
  logic                    reset;
  logic                    in_val;
  logic                    in_rdy;
  logic signed [WIDTH-1:0] in_c_r, in_c_i, in_z0_r, in_z0_i;
  logic                    in_julia;
  logic [ITER_W-1:0]       in_max_iter;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_val;
  logic                    out_rdy;
  logic [ITER_W-1:0]       out_iter;
  logic                    out_escaped;
  logic [TAG_W-1:0]        out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  mandel_iter_core #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_c_r(in_c_r), .in_c_i(in_c_i), .in_z0_r(in_z0_r), .in_z0_i(in_z0_i),
    .in_julia(in_julia), .in_max_iter(in_max_iter), .in_tag(in_tag),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_iter(out_iter), .out_escaped(out_escaped), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: real-valued recurrence on scaled integers ----------------
  function automatic longint clampw(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint fxmul(input longint a, input longint b, output bit ovf);
    longint q;
    q   = (a * b) >>> FRAC;
    ovf = (q > MAXV) || (q < MINV);
    return clampw(q);
  endfunction

  function automatic void ref_model(input longint cr, input longint ci, input longint zr0,
                                    input longint zi0, input int max_iter,
                                    output int iter, output bit esc, output int k);
    longint zr, zi, sr, si, cx;
    bit o1, o2, o3;
    int cap;
    zr  = zr0;
    zi  = zi0;
    cap = (max_iter == 0) ? 1 : max_iter;
    for (int n = 0; n < cap; n++) begin
      sr = fxmul(zr, zr, o1);
      si = fxmul(zi, zi, o2);
      cx = fxmul(zr, zi, o3);
      if ((sr + si >= 4 * ONE) || o1 || o2 ||
          zr > 2 * ONE || zr < -2 * ONE || zi > 2 * ONE || zi < -2 * ONE) begin
        iter = n; esc = 1'b1; k = n + 1;
        return;
      end
      zr = clampw(clampw(sr - si) + cr);
      zi = clampw(clampw(2 * cx) + ci);
    end
    iter = cap; esc = 1'b0; k = cap;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_job(input longint cr, input longint ci, input longint zr0, input longint zi0,
                          input bit julia, input int max_iter, input logic [TAG_W-1:0] tag,
                          output bit ok);
    in_c_r = WIDTH'(cr); in_c_i = WIDTH'(ci);
    in_z0_r = WIDTH'(zr0); in_z0_i = WIDTH'(zi0);
    in_julia = julia; in_max_iter = ITER_W'(max_iter); in_tag = tag;
    in_val = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_rdy) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    // Inputs need not be held after the handshake.
    in_c_r = WIDTH'($urandom); in_c_i = WIDTH'($urandom);
    in_z0_r = WIDTH'($urandom); in_z0_i = WIDTH'($urandom);
    in_julia = 1'($urandom); in_max_iter = ITER_W'($urandom); in_tag = TAG_W'($urandom);
  endtask

  task automatic wait_result(input int budget, output int lat, output bit got);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_val) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val: got %0b want 0", out_val); end
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %0b want 0", in_rdy); end
    n_checks++; if (out_iter !== '0) begin n_fail++; $display("FAIL reset_out_iter: got %0d want 0", out_iter); end
    n_checks++; if (out_escaped !== 1'b0) begin n_fail++; $display("FAIL reset_out_escaped: got %0b want 0", out_escaped); end
    n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %0h want 0", out_tag); end
    #20 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_rdy: got %0b want 1", in_rdy); end
  endtask

  typedef struct {
    longint cr, ci, zr, zi;
    bit julia;
    int max_iter;
    logic [TAG_W-1:0] tag;
    int exp_iter;
    bit exp_esc;
    int exp_lat;
  } dcase_t;

  task automatic test_directed();
    dcase_t cs[7];
    longint c39;
    bit ok, got;
    int lat;
    c39 = longint'(3.9 * 8388608.0);
    cs[0] = '{0, 0, 0, 0, 1'b0, 100, 19'h00001, 100, 1'b0, 301};
    cs[1] = '{2 * ONE, 0, 0, 0, 1'b0, 100, 19'h00002, 1, 1'b1, 7};
    cs[2] = '{-2 * ONE, 0, 0, 0, 1'b0, 100, 19'h00003, 1, 1'b1, 7};
    cs[3] = '{ONE / 4, 0, 0, 0, 1'b0, 50, 19'h00004, 50, 1'b0, 151};
    cs[4] = '{0, 0, (3 * ONE) / 2, 0, 1'b1, 20, 19'h5A5A5, 1, 1'b1, 7};
    cs[5] = '{0, 0, 0, 0, 1'b0, 0, 19'h00006, 1, 1'b0, 4};
    cs[6] = '{c39, c39, 0, 0, 1'b0, 100, 19'h00007, 1, 1'b1, 7};
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_job(cs[i].cr, cs[i].ci, cs[i].zr, cs[i].zi, cs[i].julia, cs[i].max_iter, cs[i].tag, ok);
      wait_result(1000, lat, got);
      n_checks++; if (!(ok && got)) begin n_fail++; $display("FAIL dir%0d_handshake: accepted %0b result %0b want 1 1", i, ok, got); end
      n_checks++; if (out_iter !== ITER_W'(cs[i].exp_iter)) begin n_fail++; $display("FAIL dir%0d_iter: got %0d want %0d", i, out_iter, cs[i].exp_iter); end
      n_checks++; if (out_escaped !== cs[i].exp_esc) begin n_fail++; $display("FAIL dir%0d_escaped: got %0b want %0b", i, out_escaped, cs[i].exp_esc); end
      n_checks++; if (out_tag !== cs[i].tag) begin n_fail++; $display("FAIL dir%0d_tag: got %0h want %0h", i, out_tag, cs[i].tag); end
      n_checks++; if (lat != cs[i].exp_lat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, cs[i].exp_lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    bit ok, got;
    int lat;
    send_job(0, 0, 0, 0, 1'b0, 10, 19'h0AAAA, ok);
    in_val = 1'b1; in_tag = 19'h05555; in_max_iter = 10'd3; in_c_r = WIDTH'(2 * ONE);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL busy_in_rdy%0d: got %0b want 0", i, in_rdy); end
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    wait_result(1000, lat, got);
    lat = lat + 5;
    n_checks++; if (!(ok && got)) begin n_fail++; $display("FAIL busy_handshake: accepted %0b result %0b want 1 1", ok, got); end
    n_checks++; if (out_tag !== 19'h0AAAA) begin n_fail++; $display("FAIL busy_tag: got %0h want aaaa", out_tag); end
    n_checks++; if (out_iter !== 10'd10 || out_escaped !== 1'b0) begin n_fail++; $display("FAIL busy_result: got %0d/%0b want 10/0", out_iter, out_escaped); end
    n_checks++; if (lat != 31) begin n_fail++; $display("FAIL busy_latency: got %0d want 31", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok, got;
    int lat;
    out_rdy = 1'b0;
    send_job(2 * ONE, 0, 0, 0, 1'b0, 100, 19'h01234, ok);
    wait_result(1000, lat, got);
    n_checks++; if (!(ok && got)) begin n_fail++; $display("FAIL bp_handshake: accepted %0b result %0b want 1 1", ok, got); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_val !== 1'b1 || in_rdy !== 1'b0 || out_iter !== 10'd1 ||
          out_escaped !== 1'b1 || out_tag !== 19'h01234) begin
        n_fail++;
        $display("FAIL bp_hold%0d: val %0b rdy %0b iter %0d esc %0b tag %0h want 1 0 1 1 1234",
                 i, out_val, in_rdy, out_iter, out_escaped, out_tag);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_val !== 1'b0 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release: val %0b rdy %0b want 0 1", out_val, in_rdy); end
  endtask

  task automatic test_random();
    bit ok, got, julia, exp_esc;
    longint cr, ci, zr0, zi0;
    int max_iter, exp_iter, k, lat;
    logic [TAG_W-1:0] tag;
    out_rdy = 1'b1;
    for (int t = 0; t < 30; t++) begin
      cr = longint'($urandom_range(0, 5 * ONE)) - (5 * ONE) / 2;
      ci = longint'($urandom_range(0, 5 * ONE)) - (5 * ONE) / 2;
      julia = 1'($urandom);
      zr0 = julia ? longint'($urandom_range(0, 3 * ONE)) - (3 * ONE) / 2 : 0;
      zi0 = julia ? longint'($urandom_range(0, 3 * ONE)) - (3 * ONE) / 2 : 0;
      max_iter = $urandom_range(0, 40);
      tag = TAG_W'($urandom);
      ref_model(cr, ci, zr0, zi0, max_iter, exp_iter, exp_esc, k);
      send_job(cr, ci, julia ? zr0 : longint'($urandom), julia ? zi0 : longint'($urandom),
               julia, max_iter, tag, ok);
      wait_result(400, lat, got);
      n_checks++; if (!(ok && got)) begin n_fail++; $display("FAIL rnd%0d_handshake: accepted %0b result %0b want 1 1", t, ok, got); end
      n_checks++; if (out_iter !== ITER_W'(exp_iter)) begin n_fail++; $display("FAIL rnd%0d_iter: got %0d want %0d", t, out_iter, exp_iter); end
      n_checks++; if (out_escaped !== exp_esc) begin n_fail++; $display("FAIL rnd%0d_escaped: got %0b want %0b", t, out_escaped, exp_esc); end
      n_checks++; if (out_tag !== tag) begin n_fail++; $display("FAIL rnd%0d_tag: got %0h want %0h", t, out_tag, tag); end
      n_checks++; if (lat != 3 * k + 1) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, 3 * k + 1); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got, seen;
    int lat;
    out_rdy = 1'b1;
    send_job(0, 0, 0, 0, 1'b0, 100, 19'h00BAD, ok);
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++; if (out_val !== 1'b0 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: val %0b rdy %0b want 0 0", out_val, in_rdy); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_idle: rdy %0b want 1", in_rdy); end
    seen = 1'b0;
    for (int i = 0; i < 320; i++) begin
      if (out_val) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_result: out_val seen %0b want 0", seen); end
    send_job(ONE / 4, 0, 0, 0, 1'b0, 5, 19'h00C0D, ok);
    wait_result(1000, lat, got);
    n_checks++; if (!(ok && got)) begin n_fail++; $display("FAIL after_reset_handshake: accepted %0b result %0b want 1 1", ok, got); end
    n_checks++;
    if (out_iter !== 10'd5 || out_escaped !== 1'b0 || out_tag !== 19'h00C0D || lat != 16) begin
      n_fail++;
      $display("FAIL after_reset_job: iter %0d esc %0b tag %0h lat %0d want 5 0 c0d 16",
               out_iter, out_escaped, out_tag, lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    in_val = 1'b0; in_c_r = '0; in_c_i = '0; in_z0_r = '0; in_z0_i = '0;
    in_julia = 1'b0; in_max_iter = '0; in_tag = '0;
    out_rdy = 1'b1;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
